terrain_spawner: RTL and testbench



---
 rtl/terrain_spawner_pkg.sv | 32 +++
 rtl/terrain_spawner.sv | 131 +++++++++++++
 tb/tb_terrain_spawner.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/terrain_spawner_pkg.sv
// Shared types for the terrain spawn path: screen geometry, level ROM entry
// layout and the spawner state encoding.
package terrain_spawner_pkg;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } POSITION;

  typedef struct packed {
    POSITION center;
    POSITION radius;
  } RECT;

  localparam logic [7:0] END_ID = 8'hFF;

  // 48-bit ROM word: [47:40] id, [39:20] center, [19:0] radius
  typedef struct packed {
    logic [7:0] terrain_id;
    RECT        area;
  } LEVEL_ENTRY;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KILL,
    S_FETCH,
    S_CHECK,
    S_SPAWN,
    S_DONE
  } spawn_state_e;

endpackage

// File: rtl/terrain_spawner.sv
// Level loader: clears all terrain, then walks one level's entry list in the
// synchronous level ROM and issues one spawn pulse per entry.
module terrain_spawner
  import terrain_spawner_pkg::*;
#(
  parameter int         NUM_LEVELS  = 4,
  parameter int         MAX_ENTRIES = 64,
  parameter int         ADDR_W      = 8,
  parameter logic [7:0] END_MARK    = END_ID
) (
  input  logic              clk,
  input  logic              reset_h,
  input  logic              loadLevel,
  input  logic [7:0]        levelNum,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [47:0]       romData,
  output logic              sigKill,
  output logic              sigSpawn,
  output logic [7:0]        terrainID,
  output RECT               spawnArea,
  output logic              busy,
  output logic              done,
  output logic [7:0]        spawnCount
);

  // One extra bit so the slot limit is detectable without wrapping.
  localparam int IDX_W = $clog2(MAX_ENTRIES) + 1;

  spawn_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       level_q, level_d;
  logic [7:0]       shadow_q, shadow_d;
  logic             sig_kill_q, sig_kill_d;
  logic             sig_spawn_q, sig_spawn_d;
  logic [7:0]       id_q, id_d;
  RECT              area_q, area_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       count_q, count_d;
  LEVEL_ENTRY       entry;

  assign entry = LEVEL_ENTRY'(romData);

  assign romAddr = (state_q == S_IDLE) ? '0 :
                   ADDR_W'(level_q) * ADDR_W'(MAX_ENTRIES) + ADDR_W'(idx_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    level_d  = level_q;
    shadow_d = shadow_q;
    id_d     = '0;
    area_d   = '0;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (loadLevel) begin
          level_d = levelNum;
          state_d = S_KILL;
        end
      end
      S_KILL: begin
        idx_d    = '0;
        shadow_d = '0;
        state_d  = (int'(level_q) >= NUM_LEVELS) ? S_DONE : S_FETCH;
      end
      S_FETCH: state_d = S_CHECK;
      S_CHECK: begin
        if (entry.terrain_id == END_MARK) begin
          state_d = S_DONE;
        end else begin
          id_d    = entry.terrain_id;
          area_d  = entry.area;
          state_d = S_SPAWN;
        end
      end
      S_SPAWN: begin
        idx_d    = idx_q + IDX_W'(1);
        shadow_d = shadow_q + 8'd1;
        state_d  = (idx_q == IDX_W'(MAX_ENTRIES - 1)) ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the state being entered.
    sig_kill_d  = (state_d == S_KILL);
    sig_spawn_d = (state_d == S_SPAWN);
    busy_d      = (state_d == S_KILL) || (state_d == S_FETCH) ||
                  (state_d == S_CHECK) || (state_d == S_SPAWN);
    done_d      = (state_d == S_DONE);
    if (state_d == S_DONE) count_d = shadow_d;
  end

  always_ff @(posedge clk) begin
    if (reset_h) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      level_q     <= '0;
      shadow_q    <= '0;
      sig_kill_q  <= 1'b0;
      sig_spawn_q <= 1'b0;
      id_q        <= '0;
      area_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      shadow_q    <= shadow_d;
      sig_kill_q  <= sig_kill_d;
      sig_spawn_q <= sig_spawn_d;
      id_q        <= id_d;
      area_q      <= area_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

  assign sigKill    = sig_kill_q;
  assign sigSpawn   = sig_spawn_q;
  assign terrainID  = id_q;
  assign spawnArea  = area_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign spawnCount = count_q;

endmodule

// File: tb/tb_terrain_spawner.sv
// Scoreboard bench: a level-list model predicts kill/spawn/done events with
// their cycle numbers; a monitor pops and compares whenever the DUT pulses.
module tb_terrain_spawner;
  import terrain_spawner_pkg::*;

  logic       clk = 0;
  logic       reset_h = 1;
  logic       loadLevel = 0;
  logic [7:0] levelNum = 0;
  logic [7:0] romAddr;
  logic [47:0] romData = '0;
  logic       sigKill, sigSpawn, busy, done;
  logic [7:0] terrainID, spawnCount;
  RECT        spawnArea;

  terrain_spawner dut (
    .clk(clk), .reset_h(reset_h), .loadLevel(loadLevel), .levelNum(levelNum),
    .romAddr(romAddr), .romData(romData), .sigKill(sigKill), .sigSpawn(sigSpawn),
    .terrainID(terrainID), .spawnArea(spawnArea), .busy(busy), .done(done),
    .spawnCount(spawnCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [47:0] rom [256];
  always @(posedge clk) romData <= rom[romAddr];

  typedef struct {
    int          kind;   // 0 kill, 1 spawn, 2 done
    int          at;
    logic [7:0]  id;
    RECT         area;
    int          cnt;
  } ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;
  logic mon_en = 0;
  int seen_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [47:0] mk(input logic [7:0] id);
    logic [39:0] r;
    r = 40'({$urandom, $urandom});
    return {id, r};
  endfunction

  // Reference: walk the level list as the game designer sees it.
  task automatic predict(input int lvl, input int n, input int cut,
                         output int done_at, output int last_addr);
    ev_t e;
    int cnt = 0;
    int s;
    e.id = 0; e.area = '0; e.cnt = 0;
    e.kind = 0; e.at = n + 1;
    if (e.at <= cut) q.push_back(e);
    last_addr = -1;
    if (lvl >= 4) begin
      done_at = n + 2;
    end else begin
      done_at = n + 4 + 3 * 63 + 1;
      for (s = 0; s < 64; s++) begin
        logic [47:0] w;
        w = rom[lvl * 64 + s];
        last_addr = lvl * 64 + s;
        if (w[47:40] == END_ID) begin
          done_at = n + 4 + 3 * s;
          break;
        end
        e.kind = 1; e.at = n + 4 + 3 * s; e.id = w[47:40]; e.area = RECT'(w[39:0]);
        if (e.at <= cut) q.push_back(e);
        cnt++;
      end
    end
    e.kind = 2; e.at = done_at; e.id = 0; e.area = '0; e.cnt = cnt;
    if (e.at <= cut) q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset_h) begin
      if (busy) seen_addr = int'(romAddr);
      if (sigKill && sigSpawn) chk("kill_spawn_overlap", 1, 0);
      if (!sigSpawn) chk("idle_fields_zero", {terrainID, spawnArea}, 0);
      if (sigKill || sigSpawn || done) begin
        ev_t e;
        int k;
        k = sigKill ? 0 : (sigSpawn ? 1 : 2);
        if (q.size() == 0) begin
          chk("unexpected_event_kind", k, 99);
        end else begin
          e = q.pop_front();
          chk("event_kind", k, e.kind);
          chk("event_cycle", cyc, e.at);
          if (k == 1) begin
            chk("spawn_id", terrainID, e.id);
            chk("spawn_area", spawnArea, e.area);
          end
          if (k == 2) begin
            chk("spawn_count", spawnCount, e.cnt);
            chk("busy_at_done", busy, 0);
          end else begin
            chk("busy_active", busy, 1);
          end
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"}, {sigKill, sigSpawn, terrainID, spawnArea, busy, done, spawnCount}, 0);
    chk({tag, "_romaddr"}, romAddr, 0);
  endtask

  task automatic do_load(input int lvl, input bit perturb, input int reset_off);
    int n, dc, la, cut;
    @(posedge clk); #1;
    n = cyc;
    loadLevel = 1; levelNum = 8'(lvl);
    seen_addr = 0;
    cut = (reset_off > 0) ? n + reset_off : 1 << 30;
    predict(lvl, n, cut, dc, la);
    @(posedge clk); #1;
    loadLevel = 0; levelNum = 8'($urandom);
    if (reset_off > 0) begin
      while (cyc < n + reset_off) begin @(posedge clk); #1; end
      reset_h = 1;
      @(posedge clk); #1;
      reset_h = 0;
      @(negedge clk);
      check_all_zero("after_reset");
      repeat (2) @(posedge clk);
      chk("queue_drained_reset", q.size(), 0);
      q.delete();
    end else begin
      while (cyc < dc) begin
        @(posedge clk); #1;
        if (perturb && cyc < dc) begin
          loadLevel = 1'($urandom_range(0, 1));
          levelNum  = 8'($urandom);
        end else begin
          loadLevel = 0;
        end
      end
      loadLevel = 0;
      repeat (3) @(posedge clk);
      chk("queue_drained", q.size(), 0);
      q.delete();
      if (lvl < 4) chk("last_rom_addr", seen_addr, la);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = mk(8'($urandom_range(0, 254)));
    rom[0] = mk(8'd1); rom[1] = mk(8'd2); rom[2] = mk(8'd3); rom[3] = mk(END_ID);
    rom[64] = mk(END_ID);
    rom[192 + $urandom_range(1, 20)] = mk(END_ID);
    rom[130] = mk(rom[129][47:40]);

    reset_h = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset_state");
    @(posedge clk); #1;
    reset_h = 0;
    mon_en = 1;

    do_load(0, 0, 0);
    do_load(1, 0, 0);
    do_load(2, 0, 0);
    do_load(7, 0, 0);
    do_load(0, 1, 0);
    do_load(3, 1, 0);
    do_load(0, 0, 8);
    do_load(0, 0, 0);
    for (int i = 0; i < 8; i++) do_load($urandom_range(0, 5), 1'($urandom_range(0, 1)), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
